// File: rtl/jam_cost_server.sv
// jam_cost_server
// Front-end for the job-assignment solver. Receives the 8x8 worker/job cost
// matrix as a row-major valid/ready stream, stores it, and answers the
// solver's (W,J) cost lookups combinationally. The solver is held in reset
// until all 64 costs are loaded, then its final MinCost/MatchCount is
// captured into a result register offered with a valid/ack handshake.
// A run that produces no result within TIMEOUT_CYCLES is closed with
// res_error=1.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data  cost stream, beat index = {w,j}, 0..63
//   W, J, Cost               solver lookup: Cost = mem[{W,J}] (no register)
//   jam_rst                  registered reset to the solver (1 = hold)
//   jam_valid, jam_min_cost, jam_match_count   solver result
//   res_valid, res_min_cost, res_match_count, res_error, res_ack  result
//   busy                     high whenever not idle
module jam_cost_server #(
  parameter int unsigned      CNT_W          = 20,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_data,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  output logic        jam_rst,
  input  logic        jam_valid,
  input  logic [9:0]  jam_min_cost,
  input  logic [3:0]  jam_match_count,
  output logic        res_valid,
  output logic [9:0]  res_min_cost,
  output logic [3:0]  res_match_count,
  output logic        res_error,
  input  logic        res_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_W'(1);
  // The solver's Valid is unreset; it is only trusted from this count on.
  localparam logic [CNT_W-1:0] VALID_GUARD  = CNT_W'(2);

  state_t           state_reg;
  logic [5:0]       beat_cnt_reg;
  logic [CNT_W-1:0] run_cnt_reg;
  logic             in_ready_reg;
  logic             jam_rst_reg;
  logic             res_valid_reg;
  logic [9:0]       res_min_cost_reg;
  logic [3:0]       res_match_count_reg;
  logic             res_error_reg;
  logic             busy_reg;

  logic [6:0] mem [0:63];
  logic       beat_accept;

  assign beat_accept = in_valid && in_ready_reg;

  // Cost storage has no reset; it is written only by accepted beats.
  always_ff @(posedge CLK) begin
    if (beat_accept) begin
      mem[beat_cnt_reg] <= in_data;
    end
  end

  // The solver samples Cost half a cycle after W/J move, so this read
  // must stay combinational.
  assign Cost = mem[{W, J}];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg           <= IDLE;
      beat_cnt_reg        <= 6'd0;
      run_cnt_reg         <= '0;
      in_ready_reg        <= 1'b1;
      jam_rst_reg         <= 1'b1;
      res_valid_reg       <= 1'b0;
      res_min_cost_reg    <= 10'd1023;
      res_match_count_reg <= 4'd0;
      res_error_reg       <= 1'b0;
      busy_reg            <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (beat_accept) begin
            beat_cnt_reg <= beat_cnt_reg + 6'd1;
            state_reg    <= LOAD;
            busy_reg     <= 1'b1;
          end
        end

        LOAD: begin
          if (beat_accept) begin
            // Wraps to 0 on the last beat, ready for the next load.
            beat_cnt_reg <= beat_cnt_reg + 6'd1;
            if (beat_cnt_reg == 6'd63) begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b0;
              jam_rst_reg  <= 1'b0;
              run_cnt_reg  <= '0;
            end
          end
        end

        RUN: begin
          run_cnt_reg <= run_cnt_reg + CNT_W'(1);
          // A valid capture takes priority over a coincident timeout.
          if (jam_valid && (run_cnt_reg >= VALID_GUARD)) begin
            res_min_cost_reg    <= jam_min_cost;
            res_match_count_reg <= jam_match_count;
            res_error_reg       <= 1'b0;
            res_valid_reg       <= 1'b1;
            state_reg           <= DONE;
          end else if (run_cnt_reg == TIMEOUT_LAST) begin
            res_min_cost_reg    <= 10'd1023;
            res_match_count_reg <= 4'd0;
            res_error_reg       <= 1'b1;
            res_valid_reg       <= 1'b1;
            state_reg           <= DONE;
          end
        end

        DONE: begin
          // jam_rst stays low so the solver keeps holding its result.
          if (res_ack) begin
            res_valid_reg <= 1'b0;
            jam_rst_reg   <= 1'b1;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_reg;
  assign jam_rst         = jam_rst_reg;
  assign res_valid       = res_valid_reg;
  assign res_min_cost    = res_min_cost_reg;
  assign res_match_count = res_match_count_reg;
  assign res_error       = res_error_reg;
  assign busy            = busy_reg;

endmodule

// File: tb/tb_jam_cost_server.sv
// Testbench for jam_cost_server. The solver is replaced by a stub whose
// result values are chosen by the bench; the cost matrix is mirrored in a
// plain array indexed by w*8+j and filled from the matrix formula.
module tb_jam_cost_server;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       jam_rst;
  logic       jam_valid;
  logic [9:0] jam_min_cost;
  logic [3:0] jam_match_count;
  logic       res_valid;
  logic [9:0] res_min_cost;
  logic [3:0] res_match_count;
  logic       res_error;
  logic       res_ack;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] ref_mem [64];

  always #5 CLK = ~CLK;

  jam_cost_server #(
    .CNT_W          (20),
    .TIMEOUT_CYCLES (20'd100)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .W               (W),
    .J               (J),
    .Cost            (Cost),
    .jam_rst         (jam_rst),
    .jam_valid       (jam_valid),
    .jam_min_cost    (jam_min_cost),
    .jam_match_count (jam_match_count),
    .res_valid       (res_valid),
    .res_min_cost    (res_min_cost),
    .res_match_count (res_match_count),
    .res_error       (res_error),
    .res_ack         (res_ack),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // kind: 0 -> 8w+j mod 128, 1 -> w+j, 2 -> diagonal 0/100, 3 -> random
  task automatic load(input int kind, input bit gaps, input int beats);
    int acc = 0;
    int cyc = 0;
    bit vld;
    logic [6:0] v;
    while (acc < beats && cyc < 2000) begin
      vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (kind)
        0:       v = 7'((8 * (acc / 8) + (acc % 8)) % 128);
        1:       v = 7'((acc / 8) + (acc % 8));
        2:       v = ((acc / 8) == (acc % 8)) ? 7'd0 : 7'd100;
        default: v = 7'($urandom);
      endcase
      in_valid = vld;
      in_data  = vld ? v : 7'($urandom);
      if (vld) begin
        check("in_ready_load", in_ready, 1);
        ref_mem[acc] = v;
        acc++;
        if (acc == 64) check("jam_rst_before_last", jam_rst, 1);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    if (acc < beats) check("load_timeout", 0, 1);
    $display("load kind=%0d gaps=%0d beats=%0d cycles=%0d", kind, gaps, acc, cyc);
  endtask

  task automatic after_full_load();
    check("jam_rst_run_entry", jam_rst, 0);
    check("in_ready_run_entry", in_ready, 0);
    check("busy_run_entry", busy, 1);
  endtask

  task automatic readback(input bit all, input int n);
    int w, j;
    int cnt = all ? 64 : n;
    for (int i = 0; i < cnt; i++) begin
      w = all ? i / 8 : int'($urandom_range(0, 7));
      j = all ? i % 8 : int'($urandom_range(0, 7));
      W = 3'(w);
      J = 3'(j);
      #1;
      check("cost_readback", Cost, ref_mem[w * 8 + j]);
    end
    $display("readback lookups=%0d", cnt);
  endtask

  task automatic check_result(input bit err, input int mc, input int cnt);
    check("res_valid", res_valid, 1);
    check("res_error", res_error, err);
    check("res_min_cost", res_min_cost, mc);
    check("res_match_count", res_match_count, cnt);
    check("in_ready_done", in_ready, 0);
    check("jam_rst_done", jam_rst, 0);
    $display("result err=%0d min=%0d cnt=%0d", res_error, res_min_cost, res_match_count);
  endtask

  task automatic ack_result();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    jam_valid = 1'b0;
    check("res_valid_after_ack", res_valid, 0);
    check("jam_rst_after_ack", jam_rst, 1);
    check("in_ready_after_ack", in_ready, 1);
    check("busy_after_ack", busy, 0);
    $display("ack");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    RST = 1'b1; in_valid = 1'b0; in_data = 7'd0; W = 3'd0; J = 3'd0;
    jam_valid = 1'b0; jam_min_cost = 10'd0; jam_match_count = 4'd0; res_ack = 1'b0;
    step(); step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_jam_rst", jam_rst, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_min_cost", res_min_cost, 1023);
    check("rst_res_match_count", res_match_count, 0);
    check("rst_res_error", res_error, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    step();

    // A: back-to-back load of 8w+j; solver Valid high from the first RUN
    // cycle must be ignored until the third.
    load(0, 1'b0, 64);
    after_full_load();
    jam_valid = 1'b1; jam_min_cost = 10'd252; jam_match_count = 4'd0;
    step();
    check("ignore_valid_cnt0", res_valid, 0);
    check("in_ready_run", in_ready, 0);
    step();
    check("ignore_valid_cnt1", res_valid, 0);
    step();
    check_result(1'b0, 252, 0);
    W = 3'd3; J = 3'd5; #1; check("cost_3_5", Cost, 29);
    W = 3'd7; J = 3'd7; #1; check("cost_7_7", Cost, 63);
    readback(1'b0, 8);
    jam_min_cost = 10'd5; jam_match_count = 4'd9;
    step(); step(); step();
    check_result(1'b0, 252, 0);
    ack_result();

    // B: gapped load of diagonal matrix; results persist across the load;
    // an ack during RUN is ignored.
    load(2, 1'b1, 64);
    after_full_load();
    check("res_kept_min", res_min_cost, 252);
    check("res_kept_valid", res_valid, 0);
    lat = $urandom_range(2, 15);
    res_ack = 1'b1;
    for (int i = 0; i < lat; i++) begin
      step();
      check("run_no_result", res_valid, 0);
      check("run_in_ready", in_ready, 0);
    end
    check("ack_in_run_ignored", busy, 1);
    res_ack = 1'b0;
    jam_valid = 1'b1; jam_min_cost = 10'd0; jam_match_count = 4'd1;
    step();
    check_result(1'b0, 0, 1);
    readback(1'b1, 0);
    ack_result();

    // C: w+j matrix, random solver latency.
    load(1, 1'b0, 64);
    after_full_load();
    lat = $urandom_range(2, 10);
    for (int i = 0; i < lat; i++) step();
    check("run_wait_c", res_valid, 0);
    jam_valid = 1'b1; jam_min_cost = 10'd56; jam_match_count = 4'($urandom);
    step();
    check_result(1'b0, 56, int'(jam_match_count));
    readback(1'b0, 10);
    ack_result();

    // D: solver never finishes -> timeout after 100 RUN cycles.
    load(3, 1'b1, 64);
    after_full_load();
    for (int i = 0; i < 99; i++) step();
    check("no_timeout_yet", res_valid, 0);
    check("busy_before_timeout", busy, 1);
    step();
    check_result(1'b1, 1023, 0);
    readback(1'b0, 8);
    step(); step();
    check_result(1'b1, 1023, 0);
    ack_result();

    // E: valid arrives exactly on the timeout cycle -> capture wins.
    load(3, 1'b0, 64);
    after_full_load();
    for (int i = 0; i < 99; i++) step();
    check("no_timeout_yet_e", res_valid, 0);
    jam_valid = 1'b1; jam_min_cost = 10'd123; jam_match_count = 4'd7;
    step();
    check_result(1'b0, 123, 7);
    ack_result();

    // F: reset after 30 beats, then a fresh full load.
    load(3, 1'b0, 30);
    check("busy_mid_load", busy, 1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_jam_rst", jam_rst, 1);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_res_min", res_min_cost, 1023);
    step();
    RST = 1'b0;
    step();
    load(3, 1'b1, 64);
    after_full_load();
    jam_valid = 1'b1; jam_min_cost = 10'd77; jam_match_count = 4'd3;
    step();
    check("ignore_valid_f0", res_valid, 0);
    step();
    check("ignore_valid_f1", res_valid, 0);
    step();
    check_result(1'b0, 77, 3);
    readback(1'b1, 0);
    ack_result();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Upstream front-end for the job-assignment solver.
- Accepts the 8x8 worker/job cost matrix as a streamed valid/ready sequence and stores it.
- Serves the solver's (W,J) cost lookups combinationally, holds the solver in reset until the matrix is complete, and captures the solver's final MinCost/MatchCount into a result register with a valid/ack handshake.

Parameters:
- TIMEOUT_CYCLES, 20'd1000000: maximum RUN cycles before aborting with res_error.
- CNT_W, 20: width of the RUN cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  cost beat valid.
- in_ready  out  1  cost beat accepted when in_valid && in_ready.
- in_data  in  7  cost value; beats ordered row-major, index = {w,j}, 0..63.
- W  in  3  worker index from solver.
- J  in  3  job index from solver.
- Cost  out  7  combinational mem[{W,J}].
- jam_rst  out  1  registered reset driven to the solver; high holds the solver in reset.
- jam_valid  in  1  solver done flag; stays high once set.
- jam_min_cost  in  10  solver minimum cost.
- jam_match_count  in  4  solver count of minimum-cost assignments.
- res_valid  out  1  result available.
- res_min_cost  out  10  captured minimum cost.
- res_match_count  out  4  captured match count.
- res_error  out  1  qualifies res_valid; 1 means the run timed out.
- res_ack  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Storage: 64 x 7-bit register array, no reset; contents are X until loaded.
- Cost = mem[{W,J}], purely combinational. The solver samples Cost half a cycle after W/J change, so no register is allowed on this path.
- Write: on in_valid && in_ready, mem[beat_cnt] <= in_data and beat_cnt increments (6 bits).
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=1, jam_rst=1.
  - An accepted beat writes index 0, sets beat_cnt=1 and moves to LOAD.
- LOAD:
  - in_ready=1, jam_rst=1.
  - Gaps in in_valid are allowed; beat_cnt holds during gaps.
  - The beat accepted at beat_cnt==63 moves to RUN. beat_cnt wraps to 0.
- RUN:
  - in_ready=0. jam_rst is registered low on the first RUN cycle.
  - run_cnt clears on entry and increments every cycle.
  - jam_valid is ignored while run_cnt < 2, because solver Valid is unreset and may be X or stale.
  - When jam_valid=1 and run_cnt >= 2: capture res_min_cost <= jam_min_cost, res_match_count <= jam_match_count, res_error <= 0; go to DONE.
  - When run_cnt == TIMEOUT_CYCLES-1 with no valid capture: res_error <= 1, res_min_cost <= 10'd1023, res_match_count <= 0; go to DONE.
  - If jam_valid and the timeout coincide, the capture wins and res_error=0.
- DONE:
  - res_valid=1; in_ready=0; jam_rst stays low, so the solver holds FINISH.
  - Result registers are stable while res_valid=1.
  - res_ack=1 moves to IDLE: res_valid falls and jam_rst rises on the next edge.
  - res_ack outside DONE is ignored.
- Reset values:
  - State IDLE; beat_cnt=0, run_cnt=0.
  - in_ready=1, jam_rst=1.
  - res_valid=0, res_min_cost=10'd1023, res_match_count=0, res_error=0, busy=0.
- RST asserted mid-LOAD or mid-RUN: immediate return to IDLE with jam_rst=1. The partial matrix is discarded logically, and the next load overwrites from index 0.
- Result registers are not cleared by the next load. They are only updated at the RUN->DONE transition.
- Throughput: one beat per cycle. A full load takes a minimum of 64 cycles, and RUN is entered the cycle after beat 63.

Test Plan:
- Load with in_valid held high, cost[w][j] = 8*w+j (mod 128). Then drive W=3,J=5 -> Cost=29; W=7,J=7 -> Cost=63; in_ready=0 from the cycle after beat 63 until DONE.
- Load with random in_valid gaps, same data -> identical readback. jam_rst falls exactly one cycle after the 64th accepted beat.
- Full run with the real solver, diagonal matrix (cost 0 where j==w, else 100) -> res_valid=1, res_min_cost=0, res_match_count=1, res_error=0. Results hold until res_ack; jam_rst=1 the cycle after ack.
- Full run with the solver and cost[w][j] = w+j -> res_min_cost=56, res_error=0.
- jam_valid tied 0, TIMEOUT_CYCLES=100 -> DONE after 100 RUN cycles with res_error=1, res_min_cost=1023, res_match_count=0.
- RST pulse after 30 beats, then a fresh 64-beat load -> state IDLE immediately, jam_rst=1, and readback matches the new matrix only. Also: jam_valid=1 on the first RUN cycle is ignored and captured on the third.
